// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the fetch/load-store memory port arbiter.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IMEM = 1'b0,
    OWN_DMEM = 1'b1
  } owner_e;

  // Wide enough for any supported data width; sliced down to DATA_W/8 where used.
  localparam logic [127:0] MASK_ALL_ONES = '1;

endpackage

// File: rtl/mem_port_arbiter_fetch_starve_counter.sv
// Counts consecutive load/store grants taken while a fetch is waiting; saturates at the limit.
module fetch_starve_counter #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic at_max
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != CNT_MAX)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign at_max = (cnt == CNT_MAX);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between fetch (imem) and load/store (dmem), one transaction at a time.
//   state  | meaning
//   IDLE   | nothing outstanding
//   ISSUE  | o_mem_req high, latched fields on o_mem_*
//   WAIT   | accepted by memory, waiting for i_mem_rvalid
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_imem_req,
  input  logic [ADDR_W-1:0]   i_imem_addr,
  input  logic                i_imem_flush,
  output logic                o_imem_ready,
  output logic                o_imem_rvalid,
  output logic [DATA_W-1:0]   o_imem_rdata,
  input  logic                i_dmem_req,
  input  logic [ADDR_W-1:0]   i_dmem_addr,
  input  logic                i_dmem_wen,
  input  logic [DATA_W-1:0]   i_dmem_wdata,
  input  logic [DATA_W/8-1:0] i_dmem_mask,
  output logic                o_dmem_ready,
  output logic                o_dmem_rvalid,
  output logic [DATA_W-1:0]   o_dmem_rdata,
  output logic                o_mem_req,
  output logic [ADDR_W-1:0]   o_mem_addr,
  output logic                o_mem_wen,
  output logic [DATA_W-1:0]   o_mem_wdata,
  output logic [DATA_W/8-1:0] o_mem_mask,
  input  logic                i_mem_ready,
  input  logic                i_mem_rvalid,
  input  logic [DATA_W-1:0]   i_mem_rdata
);

  localparam int MASK_W = DATA_W / 8;
  localparam logic [MASK_W-1:0] MASK_ALL = MASK_ALL_ONES[MASK_W-1:0];

  state_e              state_q, state_d;
  owner_e              owner_q, owner_d;
  logic                flushed_q, flushed_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                wen_q, wen_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [MASK_W-1:0]   mask_q, mask_d;

  logic arb_slot;
  logic completing;
  logic grant_dmem;
  logic grant_imem;
  logic starve_at_max;

  assign completing = (state_q == S_WAIT) && i_mem_rvalid;
  assign arb_slot   = (state_q == S_IDLE) || completing;
  assign grant_dmem = arb_slot && i_dmem_req && !(i_imem_req && starve_at_max);
  assign grant_imem = arb_slot && i_imem_req && !grant_dmem;

  fetch_starve_counter #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve (
    .clk    (i_clk),
    .rst_n  (i_rst_n),
    .clr    (grant_imem || !i_imem_req),
    .inc    (grant_dmem && i_imem_req),
    .at_max (starve_at_max)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      owner_q   <= OWN_IMEM;
      flushed_q <= 1'b0;
      addr_q    <= '0;
      wen_q     <= 1'b0;
      wdata_q   <= '0;
      mask_q    <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      flushed_q <= flushed_d;
      addr_q    <= addr_d;
      wen_q     <= wen_d;
      wdata_q   <= wdata_d;
      mask_q    <= mask_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    flushed_d = flushed_q;
    addr_d    = addr_q;
    wen_d     = wen_q;
    wdata_d   = wdata_q;
    mask_d    = mask_q;

    case (state_q)
      S_ISSUE: if (i_mem_ready)  state_d = S_WAIT;
      S_WAIT:  if (i_mem_rvalid) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // A flushed fetch still completes on the memory side; only its response is hidden.
    if (i_imem_flush && (owner_q == OWN_IMEM) && (state_q != S_IDLE))
      flushed_d = 1'b1;
    if (completing)
      flushed_d = 1'b0;

    if (grant_dmem) begin
      state_d = S_ISSUE;
      owner_d = OWN_DMEM;
      addr_d  = i_dmem_addr;
      wen_d   = i_dmem_wen;
      wdata_d = i_dmem_wdata;
      mask_d  = i_dmem_mask;
    end else if (grant_imem) begin
      state_d = S_ISSUE;
      owner_d = OWN_IMEM;
      addr_d  = i_imem_addr;
      wen_d   = 1'b0;
      wdata_d = '0;
      mask_d  = MASK_ALL;
    end
  end

  assign o_mem_req   = (state_q == S_ISSUE);
  assign o_mem_addr  = addr_q;
  assign o_mem_wen   = wen_q;
  assign o_mem_wdata = wdata_q;
  assign o_mem_mask  = mask_q;

  assign o_imem_ready = (state_q == S_ISSUE) && i_mem_ready && (owner_q == OWN_IMEM);
  assign o_dmem_ready = (state_q == S_ISSUE) && i_mem_ready && (owner_q == OWN_DMEM);

  assign o_dmem_rvalid = completing && (owner_q == OWN_DMEM);
  assign o_imem_rvalid = completing && (owner_q == OWN_IMEM) && !flushed_q && !i_imem_flush;
  assign o_imem_rdata  = i_mem_rdata;
  assign o_dmem_rdata  = i_mem_rdata;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported backing memory between the fetch stage (imem requester) and the load/store stage (dmem requester) of the core.
- Only one transaction is outstanding at a time.
- dmem has priority, with a bounded fetch-starvation limit.
- A fetch flush drops stale instruction responses after a redirect from a branch, jal or jalr.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width; the byte-mask width is DATA_W/8
- STARVE_MAX, 4, number of consecutive dmem grants while imem waits before imem is forced a grant

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous reset, active low
- i_imem_req  in  1  fetch request; held with its address until o_imem_ready
- i_imem_addr  in  ADDR_W  fetch address
- i_imem_flush  in  1  discard any in-flight fetch response
- o_imem_ready  out  1  one-cycle pulse: fetch accepted by memory
- o_imem_rvalid  out  1  fetch data valid
- o_imem_rdata  out  DATA_W  fetch data
- i_dmem_req  in  1  load/store request; held with its fields until o_dmem_ready
- i_dmem_addr  in  ADDR_W  load/store address
- i_dmem_wen  in  1  1 = store
- i_dmem_wdata  in  DATA_W  store data
- i_dmem_mask  in  DATA_W/8  byte enables
- o_dmem_ready  out  1  one-cycle pulse: load/store accepted
- o_dmem_rvalid  out  1  load data valid, or store completion
- o_dmem_rdata  out  DATA_W  load data
- o_mem_req  out  1  request to memory
- o_mem_addr  out  ADDR_W  registered address
- o_mem_wen  out  1  registered write enable
- o_mem_wdata  out  DATA_W  registered write data
- o_mem_mask  out  DATA_W/8  registered byte mask
- i_mem_ready  in  1  memory accepts o_mem_req this cycle
- i_mem_rvalid  in  1  memory response; one per accepted transaction, including writes
- i_mem_rdata  in  DATA_W  response data

Behaviour:
- Reset is asynchronous, active low, and forces:
  - state = IDLE, owner = IMEM, flushed = 0, starve_cnt = 0
  - all o_mem_* = 0
  - all ready and rvalid outputs = 0
- States:
  - IDLE: no transaction outstanding.
  - ISSUE: o_mem_req = 1; the latched fields drive o_mem_*.
  - WAIT: request accepted; waiting for i_mem_rvalid.
- Arbitration is evaluated in IDLE, and in WAIT on the cycle i_mem_rvalid = 1:
  - Grant dmem if i_dmem_req = 1, unless i_imem_req = 1 and starve_cnt == STARVE_MAX; in that case grant imem.
  - Otherwise grant imem if i_imem_req = 1.
- On a grant:
  - Latch the requester's address, wen, wdata and mask into the o_mem_* registers. imem grants use wen = 0 and mask = all ones.
  - Set owner and go to ISSUE.
- If no request is pending, WAIT goes to IDLE on i_mem_rvalid.
- starve_cnt:
  - Increments on a dmem grant while i_imem_req = 1, saturating at STARVE_MAX.
  - Clears on any imem grant, or in any cycle where i_imem_req = 0.
- ISSUE → WAIT when i_mem_ready = 1.
  - In that same cycle, o_imem_ready or o_dmem_ready (per owner) is asserted combinationally.
  - Both ready outputs are never high together.
- Response path:
  - o_*_rdata = i_mem_rdata, passed through combinationally.
  - o_dmem_rvalid = i_mem_rvalid & WAIT & owner == DMEM.
  - o_imem_rvalid = i_mem_rvalid & WAIT & owner == IMEM & !flushed & !i_imem_flush.
- Latency:
  - A request seen in IDLE at cycle N gives o_mem_req at N+1.
  - With a 1-cycle memory (ready at N+1, rvalid at N+2), the response is at N+2.
  - Back-to-back issue from WAIT costs no idle cycle.
- Flush:
  - i_imem_flush while owner == IMEM in ISSUE or WAIT sets flushed. The transaction still completes on the memory side, but its response is suppressed.
  - flushed clears on completion.
  - Flush in IDLE, or while dmem owns the port, has no effect.
- Boundary conditions:
  - i_mem_rvalid in IDLE or ISSUE is ignored; this includes responses from before a reset.
  - Memory never returns rvalid in the same cycle as the ready that accepted the request.
  - A requester dropping req before ready is a protocol violation and is not handled.
  - A store's completion pulses o_dmem_rvalid; its rdata is don't-care.
- o_mem_req is deasserted in IDLE and WAIT, so there is exactly one outstanding transaction.

Decomposition:
- Shared package: the state enum (IDLE/ISSUE/WAIT), the owner encoding (IMEM = 0, DMEM = 1), and the all-ones mask constant.
- One natural sub-module: fetch_starve_counter, a saturating counter with clear and increment that exports the "starve_cnt == STARVE_MAX" flag.
- Everything else is inline.

Test Plan:
1. Load, 1-cycle memory:
   - Stimulus: i_dmem_req with addr 0x100, wen 0; memory returns rdata 0xDEADBEEF.
   - Required: o_mem_req at N+1; o_dmem_ready at N+1; o_dmem_rvalid with 0xDEADBEEF at N+2.
2. Simultaneous requests:
   - Stimulus: imem at 0x0 and dmem at 0x200, both asserted in IDLE.
   - Required: dmem is issued first; imem is issued in the cycle its rvalid returns; the two ready pulses are never coincident.
3. Starvation limit:
   - Stimulus: imem and dmem both held continuously.
   - Required: 4 dmem grants, then 1 imem grant, then dmem resumes.
4. Flush:
   - Stimulus: fetch at 0x40 accepted; i_imem_flush pulsed in WAIT; memory responds 3 cycles later.
   - Required: o_imem_rvalid stays 0; the next fetch to 0x80 returns normally.
5. Store with backpressure:
   - Stimulus: store of 0x12345678 with mask 0b0011; i_mem_ready held low for 5 cycles.
   - Required: o_mem_req and all fields stable for all 5 cycles; o_dmem_ready pulses once; o_dmem_rvalid pulses once.
6. Reset mid-WAIT:
   - Stimulus: i_rst_n pulsed low, then a stale i_mem_rvalid arrives.
   - Required: all outputs 0 immediately; no rvalid is forwarded; the next request proceeds normally.
